lif_layer: RTL

- Time-multiplexed layer of N_NEURONS leaky integrate-and-fire neurons sharing one N_INPUTS-bit binary spike input vector.
- Each neuron has a binary weight row, a membrane potential, a refractory counter and a common programmable threshold and leak.
- One input vector is one timestep. The layer evaluates neurons one per cycle and presents the resulting spike vector with a valid pulse.
- Successor to the single fixed-width neuron: parametrised fan-in and neuron count, serial weight load, reset-by-subtraction, saturation, refractory period.

---
 rtl/lif_pkg.sv | 32 +++
 rtl/lif_layer_if.sv | 37 +++
 rtl/lif_update.sv | 54 +++++
 rtl/lif_layer.sv | 123 ++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared constants, types and helpers for the leaky integrate-and-fire layer.
package lif_pkg;

    localparam int DEF_N_INPUTS  = 8;
    localparam int DEF_N_NEURONS = 4;
    localparam int DEF_U_WIDTH   = 6;
    localparam int DEF_REF_WIDTH = 3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // A one-neuron layer still needs a 1-bit select port.
    function automatic int sel_width(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

    typedef logic [DEF_U_WIDTH-1:0]   membrane_t;
    typedef logic [DEF_REF_WIDTH-1:0] ref_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_DONE
    } state_t;

endpackage

// File: rtl/lif_layer_if.sv
// Bus bundle for lif_layer: config shift port, timestep handshake, spike and membrane readout.
interface lif_layer_if
    import lif_pkg::*;
#(
    parameter int N_INPUTS  = DEF_N_INPUTS,
    parameter int N_NEURONS = DEF_N_NEURONS,
    parameter int U_WIDTH   = DEF_U_WIDTH,
    parameter int REF_WIDTH = DEF_REF_WIDTH
);
    localparam int SEL_W = sel_width(N_NEURONS);

    logic                 cfg_en;
    logic                 cfg_bit;
    logic [U_WIDTH-1:0]   threshold;
    logic [2:0]           leak_shift;
    logic [REF_WIDTH-1:0] ref_period;
    logic [N_INPUTS-1:0]  x_in;
    logic                 x_valid;
    logic                 x_ready;
    logic [N_NEURONS-1:0] spike_out;
    logic                 spike_valid;
    logic [SEL_W-1:0]     u_sel;
    logic [U_WIDTH-1:0]   u_out;

    modport master (
        output cfg_en, cfg_bit, threshold, leak_shift, ref_period,
        output x_in, x_valid, u_sel,
        input  x_ready, spike_out, spike_valid, u_out
    );

    modport slave (
        input  cfg_en, cfg_bit, threshold, leak_shift, ref_period,
        input  x_in, x_valid, u_sel,
        output x_ready, spike_out, spike_valid, u_out
    );

endinterface

// File: rtl/lif_update.sv
// Combinational single-neuron LIF step: leak, integrate, saturate, fire, refractory.
module lif_update #(
    parameter int N_INPUTS  = 8,
    parameter int U_WIDTH   = 6,
    parameter int REF_WIDTH = 3
) (
    input  logic [U_WIDTH-1:0]   u,
    input  logic [REF_WIDTH-1:0] ref_cnt,
    input  logic [N_INPUTS-1:0]  w_row,
    input  logic [N_INPUTS-1:0]  x,
    input  logic [U_WIDTH-1:0]   theta,
    input  logic [2:0]           leak_shift,
    input  logic [REF_WIDTH-1:0] ref_period,
    output logic [U_WIDTH-1:0]   u_next,
    output logic [REF_WIDTH-1:0] ref_next,
    output logic                 spike
);
    localparam logic [U_WIDTH:0] U_MAX = {1'b0, {U_WIDTH{1'b1}}};

    logic [U_WIDTH:0]   pop;
    logic [U_WIDTH:0]   sum;
    logic [U_WIDTH-1:0] theta_eff;
    logic [U_WIDTH-1:0] leaked;
    logic [U_WIDTH-1:0] sat;

    always_comb begin
        pop = '0;
        for (int b = 0; b < N_INPUTS; b++) begin
            pop = pop + (U_WIDTH+1)'(w_row[b] & x[b]);
        end
    end

    // A zero threshold would make a silent neuron fire forever.
    assign theta_eff = (theta == '0) ? U_WIDTH'(1) : theta;
    assign leaked    = (leak_shift == 3'd0) ? u : u - (u >> leak_shift);
    assign sum       = {1'b0, leaked} + pop;
    assign sat       = (sum > U_MAX) ? U_MAX[U_WIDTH-1:0] : sum[U_WIDTH-1:0];

    always_comb begin
        u_next   = u;
        ref_next = ref_cnt;
        spike    = 1'b0;
        if (ref_cnt != '0) begin
            ref_next = ref_cnt - REF_WIDTH'(1);
        end else if (sat >= theta_eff) begin
            spike    = 1'b1;
            u_next   = sat - theta_eff;
            ref_next = ref_period;
        end else begin
            u_next   = sat;
        end
    end

endmodule

// File: rtl/lif_layer.sv
// Time-multiplexed LIF layer: one shared update datapath walks the neurons one per cycle.
module lif_layer
    import lif_pkg::*;
#(
    parameter int N_INPUTS  = DEF_N_INPUTS,
    parameter int N_NEURONS = DEF_N_NEURONS,
    parameter int U_WIDTH   = DEF_U_WIDTH,
    parameter int REF_WIDTH = DEF_REF_WIDTH
) (
    input  logic      clk,
    input  logic      rst_n,
    lif_layer_if.slave bus
);
    localparam int                SEL_W  = sel_width(N_NEURONS);
    localparam int                W_BITS = N_INPUTS * N_NEURONS;
    localparam logic [SEL_W-1:0]  LAST   = SEL_W'(N_NEURONS - 1);

    state_t state, state_nxt;

    logic [W_BITS-1:0]                     w_chain;
    logic [N_NEURONS-1:0][N_INPUTS-1:0]    w_rows;
    logic [N_NEURONS-1:0][U_WIDTH-1:0]     u_mem;
    logic [N_NEURONS-1:0][REF_WIDTH-1:0]   ref_mem;
    logic [SEL_W-1:0]                      idx;
    logic [N_INPUTS-1:0]                   x_lat;
    logic [N_NEURONS-1:0]                  spk_acc;
    logic [N_NEURONS-1:0]                  spk_set;
    logic [N_NEURONS-1:0]                  spike_q;

    logic                 x_fire;
    logic                 cfg_fire;
    logic                 last;
    logic [U_WIDTH-1:0]   u_next;
    logic [REF_WIDTH-1:0] ref_next;
    logic                 spike;

    // Row i lives at chain[i*N_INPUTS +: N_INPUTS], so the first bit shifted ends up at the top.
    assign w_rows   = w_chain;
    assign x_fire   = (state == ST_IDLE) && bus.x_valid && !bus.cfg_en;
    assign cfg_fire = (state == ST_IDLE) && bus.cfg_en;
    assign last     = (state == ST_EVAL) && (idx == LAST);

    lif_update #(
        .N_INPUTS  (N_INPUTS),
        .U_WIDTH   (U_WIDTH),
        .REF_WIDTH (REF_WIDTH)
    ) u_update (
        .u          (u_mem[idx]),
        .ref_cnt    (ref_mem[idx]),
        .w_row      (w_rows[idx]),
        .x          (x_lat),
        .theta      (bus.threshold),
        .leak_shift (bus.leak_shift),
        .ref_period (bus.ref_period),
        .u_next     (u_next),
        .ref_next   (ref_next),
        .spike      (spike)
    );

    always_comb begin
        spk_set      = spk_acc;
        spk_set[idx] = spike;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        bus.x_ready     = 1'b0;
        bus.spike_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.x_ready = !bus.cfg_en;
                if (x_fire) state_nxt = ST_EVAL;
            end
            ST_EVAL: begin
                if (last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                bus.spike_valid = 1'b1;
                state_nxt       = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_chain <= '0;
            u_mem   <= '0;
            ref_mem <= '0;
            idx     <= '0;
            x_lat   <= '0;
            spk_acc <= '0;
            spike_q <= '0;
        end else begin
            if (cfg_fire) w_chain <= {w_chain[W_BITS-2:0], bus.cfg_bit};
            if (x_fire) begin
                x_lat   <= bus.x_in;
                idx     <= '0;
                spk_acc <= '0;
            end
            if (state == ST_EVAL) begin
                u_mem[idx]   <= u_next;
                ref_mem[idx] <= ref_next;
                spk_acc      <= spk_set;
                idx          <= idx + SEL_W'(1);
                // Publish on the last neuron so spike_out is already stable in DONE.
                if (last) begin
                    spike_q <= spk_set;
                    idx     <= '0;
                end
            end
        end
    end

    assign bus.spike_out = spike_q;
    assign bus.u_out     = u_mem[bus.u_sel];

endmodule
